// File: rtl/spsram_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spsram_bank_ctrl
//  Purpose  : Request-side controller for a banked single-port SRAM array.
//             Accepts read/write requests on a valid/ready handshake. Each
//             flat address is split into a one-hot bank select and a word
//             address. The controller drives the shared SRAM port and
//             captures the 1-cycle synchronous read data of the selected bank.
//             Read data returns in order through a 2-entry response buffer
//             that honours backpressure. Writes are posted and give no
//             response.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        clock, all state on rising edge
//    rst_n      in   1        synchronous active-low reset
//    req_valid  in   1        request present
//    req_ready  out  1        request accepted when req_valid & req_ready
//    req_we     in   1        1 = write, 0 = read
//    req_addr   in   BW+AW    {bank index, word address}
//    req_wdata  in   DW       write data
//    rsp_valid  out  1        read data available
//    rsp_ready  in   1        consumer takes rsp_data on rsp_valid & rsp_ready
//    rsp_data   out  DW       head of response buffer, 0 while empty
//    mem_addr   out  AW       SRAM word address, common to all banks
//    mem_din    out  DW       SRAM write data
//    mem_bs     out  NB       one-hot bank select
//    mem_we     out  1        SRAM write enable
//    mem_dout   in   DW*NB    concatenated bank read data, bank i at slice i
// ============================================================================
module spsram_bank_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int NB    = 4,
    parameter int BW    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BW+AW-1:0]     req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_din,
    output logic [NB-1:0]        mem_bs,
    output logic                 mem_we,
    input  logic [DW*NB-1:0]     mem_dout
);

    // Bank count widened by one bit so the range check also works when NB
    // is not a power of two and the bank field can encode missing banks.
    localparam logic [BW:0] c_NB_LIMIT = (BW + 1)'(NB);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]    r_buf_cnt;     // response buffer occupancy, 0..2
    logic          r_rd_pend;     // read issued last cycle, data due now
    logic [BW-1:0] r_rd_bank;     // bank of the pending read
    logic [DW-1:0] r_buf [2];     // response buffer storage
    logic          r_wr_ptr;      // buffer tail
    logic          r_rd_ptr;      // buffer head

    // ------------------------------------------------------------------
    // Combinational decode and handshake
    // ------------------------------------------------------------------
    logic [BW-1:0] w_bank;
    logic          w_bank_ok;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_accept;
    logic          w_issue;
    logic          w_rd_accept;
    logic [DW-1:0] w_rd_data;

    assign w_bank    = req_addr[BW+AW-1:AW];
    assign w_bank_ok = ({1'b0, w_bank} < c_NB_LIMIT);

    assign rsp_valid = (r_buf_cnt != 2'd0);
    assign rsp_data  = rsp_valid ? r_buf[r_rd_ptr] : '0;
    assign w_pop     = rsp_valid & rsp_ready;

    // Reads that are buffered or in flight, minus the one leaving this
    // cycle. A new read needs a free slot at the time its data lands, so
    // this count must stay below the buffer depth. The pop term lets a
    // full buffer keep streaming one request per cycle. A pop implies
    // r_buf_cnt >= 1, so the subtraction cannot wrap.
    assign w_occ     = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign req_ready = rst_n & (w_occ < 3'd2);

    assign w_accept    = req_valid & req_ready;
    assign w_issue     = w_accept & w_bank_ok;
    assign w_rd_accept = w_accept & ~req_we;

    // ------------------------------------------------------------------
    // Shared SRAM port, driven in the acceptance cycle
    // ------------------------------------------------------------------
    assign mem_addr = req_addr[AW-1:0];
    assign mem_din  = req_wdata;
    assign mem_we   = w_issue & req_we;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank_sel
            assign mem_bs[gi] = w_issue & (w_bank == BW'(gi));
        end
    endgenerate

    // Select the pending bank's read slice. A bank index with no physical
    // bank matches no slice, so such reads return zeros but still respond.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (r_rd_bank == BW'(i)) begin
                w_rd_data = mem_dout[DW*i +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read tracking and response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_cnt <= 2'd0;
            r_rd_pend <= 1'b0;
            r_rd_bank <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_bank <= w_bank;
            end

            // SRAM data for last cycle's read is valid now; push it.
            if (r_rd_pend) begin
                r_buf[r_wr_ptr] <= w_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            // Push and pop together leave the occupancy unchanged.
            r_buf_cnt <= r_buf_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
